// File: rtl/sar_readout.sv
// SAR readout buffer: captures one result word per clk_sample rising edge, tags it with a
// sequence number and presents it on a ready/valid stream through a small FIFO. The first
// word after reset is discarded; words lost to a full FIFO raise a sticky overflow flag.
module sar_readout #(
  parameter int unsigned BITS  = 9,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned TAGW  = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            clk_sample,
  input  logic [BITS:0]   result,
  output logic [BITS:0]   out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW:0]     count,
  output logic            overflow,
  input  logic            clear_ovf
);

  localparam logic [AW:0]   CountFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CountZero = '0;
  localparam logic [AW-1:0] PtrOne    = AW'(1);
  localparam logic [AW:0]   CountOne  = (AW + 1)'(1);

  // FIFO storage (no reset needed: contents are only read when count says they are valid)
  logic [BITS:0]   data_mem_q [DEPTH];
  logic [TAGW-1:0] tag_mem_q  [DEPTH];

  // Control state
  logic            clk_sample_q;
  logic            discard_q,  discard_d;
  logic [TAGW-1:0] seq_q,      seq_d;
  logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [AW:0]     count_q,    count_d;
  logic            overflow_q, overflow_d;
  logic            valid_q,    valid_d;
  logic [BITS:0]   head_data_q, head_data_d;
  logic [TAGW-1:0] head_tag_q,  head_tag_d;

  // Event decode
  logic cap;
  logic real_cap;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic head_is_new;

  // Decode capture, push, pop and drop for this cycle
  always_comb begin
    cap      = clk_sample & ~clk_sample_q;
    real_cap = cap & ~discard_q;
    full     = (count_q == CountFull);
    // valid_q mirrors count_q != 0, so popping never depends combinationally on out_ready
    // feeding back into out_valid.
    pop      = valid_q & out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push     = real_cap & (~full | pop);
    drop     = real_cap & full & ~pop;
  end

  // Next-state for pointers, occupancy, sequence tag, discard and overflow flags
  always_comb begin
    discard_d  = discard_q;
    seq_d      = seq_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (cap) begin
      discard_d = 1'b0;
    end
    // Tag advances on every real capture, dropped or not, so gaps are visible downstream.
    if (real_cap) begin
      seq_d = seq_q + TAGW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase

    // Setting wins over clearing in the same cycle.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Next head word: registered so out_data holds its last value once the FIFO drains
  always_comb begin
    valid_d     = (count_d != CountZero);
    head_data_d = head_data_q;
    head_tag_d  = head_tag_q;
    // The incoming word lands on the new head slot only when nothing else is left ahead of it.
    head_is_new = push & (wr_ptr_q == rd_ptr_d);
    if (valid_d) begin
      if (head_is_new) begin
        head_data_d = result;
        head_tag_d  = seq_q;
      end else begin
        head_data_d = data_mem_q[rd_ptr_d];
        head_tag_d  = tag_mem_q[rd_ptr_d];
      end
    end
  end

  // Control and head registers with asynchronous reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sample_q <= 1'b0;
      discard_q    <= 1'b1;
      seq_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
      head_data_q  <= '0;
      head_tag_q   <= '0;
    end else begin
      clk_sample_q <= clk_sample;
      discard_q    <= discard_d;
      seq_q        <= seq_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      valid_q      <= valid_d;
      head_data_q  <= head_data_d;
      head_tag_q   <= head_tag_d;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= result;
      tag_mem_q[wr_ptr_q]  <= seq_q;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    out_data  = head_data_q;
    out_tag   = head_tag_q;
    out_valid = valid_q;
    count     = count_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_sar_readout.sv
// Self-checking bench for sar_readout: directed vector table, hand-written reset sequences and
// randomized traffic compared against a queue-based reference model.
module tb_sar_readout;

  localparam int unsigned BITS  = 9;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned TAGW  = 4;

  logic            clock;
  logic            reset_n;
  logic            clk_sample;
  logic [BITS:0]   result;
  logic [BITS:0]   out_data;
  logic [TAGW-1:0] out_tag;
  logic            out_valid;
  logic            out_ready;
  logic [AW:0]     count;
  logic            overflow;
  logic            clear_ovf;

  sar_readout #(.BITS(BITS), .DEPTH(DEPTH), .AW(AW), .TAGW(TAGW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clk_sample (clk_sample),
    .result     (result),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model: a queue of {data, tag} words ----------------
  typedef struct {
    logic [BITS:0]   d;
    logic [TAGW-1:0] t;
  } word_t;

  word_t           mq[$];
  logic            m_prev_cs;
  logic            m_discard;
  logic [TAGW-1:0] m_seq;
  logic            m_ovf;
  logic [BITS:0]   m_head_d;
  logic [TAGW-1:0] m_head_t;

  task automatic model_reset();
    mq.delete();
    m_prev_cs = 1'b0;
    m_discard = 1'b1;
    m_seq     = '0;
    m_ovf     = 1'b0;
    m_head_d  = '0;
    m_head_t  = '0;
  endtask

  task automatic model_step(input logic cs, input logic [BITS:0] res, input logic rdy,
                            input logic clr);
    bit is_cap;
    bit dropped;
    word_t w;
    is_cap  = cs && !m_prev_cs;
    dropped = 0;
    m_prev_cs = cs;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (is_cap) begin
      if (m_discard) begin
        m_discard = 1'b0;
      end else begin
        if (mq.size() < DEPTH) begin
          w.d = res;
          w.t = m_seq;
          mq.push_back(w);
        end else begin
          dropped = 1;
        end
        m_seq = m_seq + 1'b1;
      end
    end
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (mq.size() > 0) begin
      m_head_d = mq[0].d;
      m_head_t = mq[0].t;
    end
  endtask

  task automatic check_model();
    chk("mdl_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("mdl_count", 32'(count), 32'(mq.size()));
    chk("mdl_ovf",   32'(overflow), 32'(m_ovf));
    chk("mdl_data",  32'(out_data), 32'(m_head_d));
    chk("mdl_tag",   32'(out_tag), 32'(m_head_t));
  endtask

  // One clock cycle: drive inputs, advance model, sample just after the edge
  task automatic cycle(input logic cs, input logic [BITS:0] res, input logic rdy,
                       input logic clr);
    clk_sample = cs;
    result     = res;
    out_ready  = rdy;
    clear_ovf  = clr;
    model_step(cs, res, rdy, clr);
    @(posedge clock);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    clk_sample = 1'b0;
    result     = '0;
    out_ready  = 1'b0;
    clear_ovf  = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- Directed vector table ----------------
  typedef struct {
    logic            cs;
    logic [BITS:0]   res;
    logic            rdy;
    logic            clr;
    logic            v;
    logic [AW:0]     cnt;
    logic            o;
    logic [BITS:0]   d;
    logic [TAGW-1:0] t;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic cs, logic [BITS:0] res, logic rdy, logic clr, logic v,
                              logic [AW:0] cnt, logic o, logic [BITS:0] d, logic [TAGW-1:0] t);
    vec_t x;
    x.cs = cs; x.res = res; x.rdy = rdy; x.clr = clr;
    x.v = v; x.cnt = cnt; x.o = o; x.d = d; x.t = t;
    return x;
  endfunction

  initial begin
    do_reset();

    // Overflow/drain, tag gap, clear_ovf, full with simultaneous push and pop
    tbl.push_back(mk(1, 10'h3FF, 0, 0, 0, 0, 0, 10'h000, 0)); // discarded
    tbl.push_back(mk(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(1, 10'h001, 0, 0, 1, 1, 0, 10'h001, 0));
    tbl.push_back(mk(0, 10'h000, 0, 0, 1, 1, 0, 10'h001, 0));
    tbl.push_back(mk(1, 10'h002, 0, 0, 1, 2, 0, 10'h001, 0));
    tbl.push_back(mk(0, 10'h000, 0, 0, 1, 2, 0, 10'h001, 0));
    tbl.push_back(mk(1, 10'h003, 0, 0, 1, 3, 0, 10'h001, 0));
    tbl.push_back(mk(0, 10'h000, 0, 0, 1, 3, 0, 10'h001, 0));
    tbl.push_back(mk(1, 10'h004, 0, 0, 1, 4, 0, 10'h001, 0));
    tbl.push_back(mk(0, 10'h000, 0, 0, 1, 4, 0, 10'h001, 0));
    tbl.push_back(mk(1, 10'h005, 0, 0, 1, 4, 1, 10'h001, 0)); // dropped
    tbl.push_back(mk(0, 10'h000, 0, 0, 1, 4, 1, 10'h001, 0));
    tbl.push_back(mk(0, 10'h000, 1, 0, 1, 3, 1, 10'h002, 1));
    tbl.push_back(mk(0, 10'h000, 1, 0, 1, 2, 1, 10'h003, 2));
    tbl.push_back(mk(0, 10'h000, 1, 0, 1, 1, 1, 10'h004, 3));
    tbl.push_back(mk(0, 10'h000, 1, 0, 0, 0, 1, 10'h004, 3)); // empty, data held
    tbl.push_back(mk(0, 10'h000, 1, 0, 0, 0, 1, 10'h004, 3)); // ready ignored when empty
    tbl.push_back(mk(1, 10'h0AB, 0, 0, 1, 1, 1, 10'h0AB, 5)); // tag gap
    tbl.push_back(mk(0, 10'h000, 0, 1, 1, 1, 0, 10'h0AB, 5)); // clear alone
    tbl.push_back(mk(1, 10'h011, 0, 0, 1, 2, 0, 10'h0AB, 5));
    tbl.push_back(mk(0, 10'h000, 0, 0, 1, 2, 0, 10'h0AB, 5));
    tbl.push_back(mk(1, 10'h022, 0, 0, 1, 3, 0, 10'h0AB, 5));
    tbl.push_back(mk(0, 10'h000, 0, 0, 1, 3, 0, 10'h0AB, 5));
    tbl.push_back(mk(1, 10'h033, 0, 0, 1, 4, 0, 10'h0AB, 5));
    tbl.push_back(mk(0, 10'h000, 0, 0, 1, 4, 0, 10'h0AB, 5));
    tbl.push_back(mk(1, 10'h044, 1, 0, 1, 4, 0, 10'h011, 6)); // full push+pop
    tbl.push_back(mk(0, 10'h000, 0, 0, 1, 4, 0, 10'h011, 6));
    tbl.push_back(mk(1, 10'h055, 0, 1, 1, 4, 1, 10'h011, 6)); // drop beats clear
    tbl.push_back(mk(0, 10'h000, 0, 1, 1, 4, 0, 10'h011, 6));
    tbl.push_back(mk(0, 10'h000, 1, 0, 1, 3, 0, 10'h022, 7));
    tbl.push_back(mk(0, 10'h000, 1, 0, 1, 2, 0, 10'h033, 8));
    tbl.push_back(mk(0, 10'h000, 1, 0, 1, 1, 0, 10'h044, 9)); // pushed word last
    tbl.push_back(mk(0, 10'h000, 1, 0, 0, 0, 0, 10'h044, 9));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].cs, tbl[i].res, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_ovf", i),   32'(overflow), 32'(tbl[i].o));
      chk($sformatf("tbl%0d_data", i),  32'(out_data), 32'(tbl[i].d));
      chk($sformatf("tbl%0d_tag", i),   32'(out_tag), 32'(tbl[i].t));
    end

    // Asynchronous reset takes effect without a clock edge
    cycle(1, 10'h3C3, 0, 0);
    chk("pre_rst_tag", 32'(out_tag), 32'd11);
    cycle(0, 10'h000, 0, 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_ovf",   32'(overflow), 32'd0);
    chk("async_rst_tag",   32'(out_tag), 32'd0);
    chk("async_rst_data",  32'(out_data), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Discard then first real capture
    cycle(1, 10'h155, 0, 0);
    chk("disc_valid", 32'(out_valid), 32'd0);
    cycle(0, 10'h155, 0, 0);
    chk("disc_valid2", 32'(out_valid), 32'd0);
    cycle(1, 10'h2AA, 0, 0);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data",  32'(out_data), 32'h2AA);
    chk("first_tag",   32'(out_tag), 32'd0);
    chk("first_count", 32'(count), 32'd1);

    // Count=1 with simultaneous push and pop: new word becomes head, valid stays high
    cycle(0, 10'h000, 0, 0);
    cycle(1, 10'h1E1, 1, 0);
    chk("p1_valid", 32'(out_valid), 32'd1);
    chk("p1_data",  32'(out_data), 32'h1E1);
    chk("p1_tag",   32'(out_tag), 32'd1);
    chk("p1_count", 32'(count), 32'd1);

    // Reset mid-operation with three words buffered re-arms the discard
    cycle(0, 10'h000, 0, 0);
    cycle(1, 10'h101, 0, 0);
    cycle(0, 10'h000, 0, 0);
    cycle(1, 10'h102, 0, 0);
    chk("pre_rst6_count", 32'(count), 32'd3);
    #2;
    reset_n = 1'b0;
    clk_sample = 1'b0;
    model_reset();
    #1;
    chk("rst6_count", 32'(count), 32'd0);
    chk("rst6_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cycle(1, 10'h0F0, 0, 0);
    chk("rst6_disc_valid", 32'(out_valid), 32'd0);
    cycle(0, 10'h000, 0, 0);
    cycle(1, 10'h123, 0, 0);
    chk("rst6_data", 32'(out_data), 32'h123);
    chk("rst6_tag",  32'(out_tag), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic cs, rdy, clr;
      logic [BITS:0] res;
      cs  = ($urandom_range(0, 9) < 4);
      rdy = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      res = BITS'($urandom) ^ {($urandom_range(0, 1) == 1), {BITS{1'b0}}};
      cycle(cs, res, rdy, clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sar_readout.md
Name: sar_readout

Overview:
- Downstream consumer of the SAR conversion engine's output: watches `clk_sample` and `result`, captures one word per completed conversion, tags it with a sequence number, and buffers it in a small FIFO.
- Presents the buffered words on a ready/valid stream to the digital back end (decimator, serializer or test capture).
- Flags dropped conversions with a sticky overflow bit.
- Discards the first, invalid word produced after reset.

Parameters:
- BITS, 9, SAR resolution; the result word is BITS+1 bits wide, [BITS:0].
- DEPTH, 4, FIFO depth in words; must be a power of two and at least 2.
- AW, 2, log2(DEPTH); width of the FIFO pointers.
- TAGW, 4, sequence tag width.

Ports:
- clock  input  1  system clock; same clock as the SAR engine.
- reset_n  input  1  asynchronous active-low reset.
- clk_sample  input  1  SAR engine sample phase; its rising edge marks a freshly updated `result`.
- result  input  BITS+1  conversion word from the SAR engine.
- out_data  output  BITS+1  data word at the FIFO head.
- out_tag  output  TAGW  sequence tag of the head word.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  downstream accepts the head word.
- count  output  AW+1  FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a conversion was lost because the FIFO was full.
- clear_ovf  input  1  synchronous clear of `overflow`.

Behaviour:
- Reset (async, reset_n=0):
  - out_valid=0, count=0, overflow=0, out_tag=0, out_data=0.
  - Pointers=0, sequence counter=0, sample-edge history register=0.
  - Discard flag armed (=1).
  - Reset asserted mid-operation: all buffered words are lost immediately, with no partial output.
- Capture event:
  - cap = clk_sample & ~clk_sample_q, where clk_sample_q is clk_sample registered.
  - `result` is sampled in the same cycle that cap=1. The engine updates `result` on the edge that raises clk_sample, so the value is already stable.
- Discard:
  - The first cap after reset only clears the discard flag.
  - No push, no tag increment, no overflow.
- Every later cap is a real capture:
  - Push {result, seq} if not full.
  - If full and no pop in the same cycle: drop the word, set overflow=1.
  - seq increments by 1 mod 2^TAGW on every real capture, dropped or not, so downstream sees gaps.
- Latency: a word captured in cycle N is visible on out_data/out_tag with out_valid=1 in cycle N+1.
- Pop: a transfer occurs when out_valid & out_ready. The head advances at the clock edge. out_data/out_tag follow the new head in the next cycle.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, the push is accepted and no overflow occurs.
  - When count=1, the new word becomes the head in the next cycle and out_valid stays 1.
- Empty: out_ready is ignored; out_data holds its last value; no pointer movement.
- count rules:
  - count = count + push - pop.
  - Pointers are AW bits and wrap mod DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- overflow: set has priority over clear_ovf in the same cycle; otherwise clear_ovf=1 drives it to 0 next cycle.
- Stream rule: out_valid and the head word must not change while out_valid=1 and out_ready=0, except on reset.
- Design rules: no combinational path from out_ready to out_valid; all outputs driven from registers or FIFO storage.

Test Plan:
1. Reset check: reset_n=0 mid-cycle -> out_valid=0, count=0, overflow=0, out_tag=0 immediately, without waiting for a clock edge.
2. Discard and first capture:
   - clk_sample pulses with result=10'h155 -> discarded, out_valid stays 0.
   - Next pulse with result=10'h2AA -> one cycle later out_valid=1, out_data=10'h2AA, out_tag=0, count=1.
3. Overflow and drain:
   - out_ready=0; after discard, five captures with result=1..5 -> count=4, overflow=1, data 5 lost.
   - Drain with out_ready=1 -> data 1,2,3,4 with tags 0,1,2,3.
   - Next capture -> tag 5, showing the gap.
4. Full with simultaneous push and pop: count=4, cap=1 and out_ready=1 in the same cycle -> count stays 4, overflow stays 0, new word appears in the last position.
5. clear_ovf:
   - clear_ovf=1 in the same cycle as a drop -> overflow stays 1.
   - clear_ovf=1 alone -> overflow=0 next cycle.
6. Reset mid-operation: count=3, reset_n pulsed -> count=0 and discard re-armed; the next pulse is dropped and the following word gets tag 0.
